// File: rtl/rob_pkg.sv
// Shared results-buffer definitions: write-port payload layout and flag bit positions.
package rob_pkg;

    localparam int ROBID_W     = 4;
    localparam int FIELD_W     = 8;

    // Bit positions inside the flags byte.
    localparam int FLAG_WB     = 7;
    localparam int FLAG_HALT   = 6;
    localparam int FLAG_BRANCH = 5;

    // One completed result as it is written into the results buffer.
    typedef struct packed {
        logic [ROBID_W-1:0] robid;
        logic [FIELD_W-1:0] flags;
        logic [FIELD_W-1:0] wbs;
        logic [FIELD_W-1:0] value;
    } result_t;

    localparam int RESULT_W = $bits(result_t);

    // Assemble a result from its individual fields.
    function automatic result_t pack_result(
        input logic [ROBID_W-1:0] robid,
        input logic [FIELD_W-1:0] flags,
        input logic [FIELD_W-1:0] wbs,
        input logic [FIELD_W-1:0] value
    );
        result_t r;
        r.robid = robid;
        r.flags = flags;
        r.wbs   = wbs;
        r.value = value;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Parameterised N-way round-robin picker. Priority starts at ptr and moves
// upward with wrap-around; grant is one-hot (or zero when nothing requests).
// Kept generic so the issue-select logic can reuse it.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             any
);

    logic [N-1:0] w_rot_req;
    logic [N-1:0] w_rot_grant;

    // Rotate requests so the highest-priority port (ptr) lands at bit 0.
    always_comb begin
        w_rot_req = '0;
        for (int j = 0; j < N; j++) begin
            w_rot_req[j] = req[(j + int'(ptr)) % N];
        end
    end

    // Lowest set bit of the rotated vector is the winner.
    always_comb begin
        w_rot_grant = w_rot_req & (~w_rot_req + N'(1));
    end

    // Rotate the winner back into port numbering.
    always_comb begin
        grant = '0;
        for (int m = 0; m < N; m++) begin
            grant[m] = w_rot_grant[(m + N - int'(ptr)) % N];
        end
    end

    // Any request present means a grant is issued this cycle.
    always_comb begin
        any = |req;
    end

endmodule

// File: rtl/result_arbiter.sv
// Completion-side arbiter: each execution-unit port parks one result in a
// holding register, a round-robin picker selects one parked result per cycle,
// and the winner is written to the results buffer from registered outputs.
module result_arbiter
    import rob_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*ROBID_W-1:0]   req_robid,
    input  logic [N_REQ*FIELD_W-1:0]   req_flags,
    input  logic [N_REQ*FIELD_W-1:0]   req_wbs,
    input  logic [N_REQ*FIELD_W-1:0]   req_value,
    output logic                       rob_transmit,
    output logic [ROBID_W-1:0]         robid,
    output logic [FIELD_W-1:0]         flags,
    output logic [FIELD_W-1:0]         wbs,
    output logic [FIELD_W-1:0]         value
);

    localparam int PTR_W = $clog2(N_REQ);

    // Holding registers and round-robin state.
    logic [N_REQ-1:0]  r_held;
    result_t           r_payload [N_REQ];
    logic [PTR_W-1:0]  r_rr_ptr;

    // Registered write port toward the results buffer.
    logic              r_rob_transmit;
    result_t           r_out;

    // Combinational arbitration results.
    result_t           w_req_payload [N_REQ];
    logic [N_REQ-1:0]  w_grant;
    logic              w_any;
    logic [N_REQ-1:0]  w_ready;
    logic [N_REQ-1:0]  w_xfer;
    logic [PTR_W-1:0]  w_grant_idx;
    result_t           w_grant_payload;
    logic [PTR_W-1:0]  w_ptr_next;

    // Slice the flat per-port input buses into result structs.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_req_payload[i] = pack_result(req_robid[i*ROBID_W +: ROBID_W],
                                           req_flags[i*FIELD_W +: FIELD_W],
                                           req_wbs  [i*FIELD_W +: FIELD_W],
                                           req_value[i*FIELD_W +: FIELD_W]);
        end
    end

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (r_held),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .any   (w_any)
    );

    // A port is ready when empty or when its parked entry leaves this cycle;
    // deliberately independent of req_valid.
    always_comb begin
        w_ready = ~r_held | w_grant;
        w_xfer  = req_valid & w_ready;
    end

    // Encode the one-hot grant into an index and select the winning payload.
    always_comb begin
        w_grant_idx     = '0;
        w_grant_payload = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_grant_idx     = w_grant_idx | ({PTR_W{w_grant[i]}} & PTR_W'(i));
            w_grant_payload = w_grant_payload | ({RESULT_W{w_grant[i]}} & r_payload[i]);
        end
    end

    // Pointer moves just past the granted port, wrapping at the last port.
    always_comb begin
        if (w_grant_idx == PTR_W'(N_REQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_grant_idx + PTR_W'(1);
        end
    end

    // Holding registers: capture on transfer, release on grant; a same-edge
    // transfer on the granted port reloads it instead of clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_payload[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_xfer[i]) begin
                    r_held[i]    <= 1'b1;
                    r_payload[i] <= w_req_payload[i];
                end else if (w_grant[i]) begin
                    r_held[i]    <= 1'b0;
                    r_payload[i] <= r_payload[i];
                end else begin
                    r_held[i]    <= r_held[i];
                    r_payload[i] <= r_payload[i];
                end
            end
        end
    end

    // Round-robin pointer advances only when a grant is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= w_ptr_next;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Write-port registers: pulse the strobe per grant, keep the data otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rob_transmit <= 1'b0;
            r_out          <= '0;
        end else if (w_any) begin
            r_rob_transmit <= 1'b1;
            r_out          <= w_grant_payload;
        end else begin
            r_rob_transmit <= 1'b0;
            r_out          <= r_out;
        end
    end

    assign req_ready    = w_ready;
    assign rob_transmit = r_rob_transmit;
    assign robid        = r_out.robid;
    assign flags        = r_out.flags;
    assign wbs          = r_out.wbs;
    assign value        = r_out.value;

endmodule

// File: tb/tb_result_arbiter.sv
// Self-checking bench for result_arbiter: directed scenarios followed by a
// randomized phase, all checked against a cycle-level reference model.
module tb_result_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*4-1:0] req_robid;
    logic [N*8-1:0] req_flags;
    logic [N*8-1:0] req_wbs;
    logic [N*8-1:0] req_value;
    logic          rob_transmit;
    logic [3:0]    robid;
    logic [7:0]    flags;
    logic [7:0]    wbs;
    logic [7:0]    value;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: parked entries, priority start, expected outputs.
    bit          m_known = 1'b0;
    bit  [N-1:0] m_held;
    logic [27:0] m_pay [N];
    int          m_ptr;
    bit  [N-1:0] m_xfer;
    bit          exp_tx;
    logic [27:0] exp_pay;

    result_arbiter #(.N_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_robid    (req_robid),
        .req_flags    (req_flags),
        .req_wbs      (req_wbs),
        .req_value    (req_value),
        .rob_transmit (rob_transmit),
        .robid        (robid),
        .flags        (flags),
        .wbs          (wbs),
        .value        (value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input bit v, input logic [3:0] rid,
                            input logic [7:0] fl, input logic [7:0] wb, input logic [7:0] val);
        req_valid[p]        = v;
        req_robid[p*4 +: 4] = rid;
        req_flags[p*8 +: 8] = fl;
        req_wbs[p*8 +: 8]   = wb;
        req_value[p*8 +: 8] = val;
    endtask

    // One clock: check ready, step the model at the edge, check outputs after it.
    task automatic cycle();
        int g;
        bit [N-1:0] rdy;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && m_held[idx]) g = idx;
        end
        rdy = ~m_held;
        if (g >= 0) rdy[g] = 1'b1;
        if (m_known) check("req_ready", 32'(req_ready), 32'(rdy));
        @(posedge clk);
        if (rst) begin
            m_known = 1'b1;
            m_held  = '0;
            m_ptr   = 0;
            m_xfer  = '0;
            exp_tx  = 1'b0;
            exp_pay = '0;
        end else begin
            m_xfer = req_valid & rdy;
            if (g >= 0) begin
                exp_tx    = 1'b1;
                exp_pay   = m_pay[g];
                m_ptr     = (g + 1) % N;
                m_held[g] = 1'b0;
            end else begin
                exp_tx = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (m_xfer[i]) begin
                    m_held[i] = 1'b1;
                    m_pay[i]  = {req_robid[i*4 +: 4], req_flags[i*8 +: 8],
                                 req_wbs[i*8 +: 8], req_value[i*8 +: 8]};
                end
            end
        end
        @(negedge clk);
        if (m_known) begin
            check("rob_transmit", 32'(rob_transmit), 32'(exp_tx));
            check("robid", 32'(robid), 32'(exp_pay[27:24]));
            check("flags", 32'(flags), 32'(exp_pay[23:16]));
            check("wbs",   32'(wbs),   32'(exp_pay[15:8]));
            check("value", 32'(value), 32'(exp_pay[7:0]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int p0v;
        int p1v;
        rst       = 1'b1;
        req_valid = '1;
        req_robid = '0;
        req_flags = '0;
        req_wbs   = '0;
        req_value = 24'h5A5A5A;

        // Reset held for two cycles with every port valid.
        for (int c = 0; c < 2; c++) begin
            cycle();
            check("rst_tx", 32'(rob_transmit), 32'd0);
            check("rst_value", 32'(value), 32'd0);
            check("rst_robid", 32'(robid), 32'd0);
        end
        rst       = 1'b0;
        req_valid = '0;
        check("ready_after_rst", 32'(req_ready), 32'h7);

        // Single request: pulse exactly one cycle, two edges after the transfer.
        set_port(0, 1'b1, 4'd3, 8'h80, 8'h21, 8'h5A);
        cycle();
        req_valid = '0;
        check("single_e0_tx", 32'(rob_transmit), 32'd0);
        cycle();
        check("single_e1_tx", 32'(rob_transmit), 32'd1);
        check("single_robid", 32'(robid), 32'd3);
        check("single_flags", 32'(flags), 32'h80);
        check("single_wbs", 32'(wbs), 32'h21);
        check("single_value", 32'(value), 32'h5A);
        cycle();
        check("single_e2_tx", 32'(rob_transmit), 32'd0);

        // Simultaneous requests from all ports with the pointer at 0.
        do_reset();
        set_port(0, 1'b1, 4'd0, 8'h00, 8'h00, 8'h10);
        set_port(1, 1'b1, 4'd1, 8'h00, 8'h00, 8'h11);
        set_port(2, 1'b1, 4'd2, 8'h00, 8'h00, 8'h12);
        cycle();
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("simul_tx", 32'(rob_transmit), 32'd1);
            check("simul_value", 32'(value), 32'(8'h10 + k));
        end
        check("simul_ptr", 32'(dut.r_rr_ptr), 32'd0);

        // Contention: ports 0 and 1 always valid with incrementing values.
        p0v = 'h20;
        p1v = 'h40;
        set_port(0, 1'b1, 4'd4, 8'h00, 8'h00, 8'(p0v));
        set_port(1, 1'b1, 4'd5, 8'h00, 8'h00, 8'(p1v));
        for (int k = 0; k < 9; k++) begin
            cycle();
            if (m_xfer[0]) p0v++;
            if (m_xfer[1]) p1v++;
            req_value[0*8 +: 8] = 8'(p0v);
            req_value[1*8 +: 8] = 8'(p1v);
            if (k >= 1) begin
                check("cont_tx", 32'(rob_transmit), 32'd1);
                check("cont_value", 32'(value),
                      32'((((k - 1) % 2) == 0 ? 'h20 : 'h40) + (k - 1) / 2));
            end
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) cycle();

        // Backpressure: ports 1 and 2 parked with the pointer at 1.
        do_reset();
        set_port(0, 1'b1, 4'd6, 8'h00, 8'h00, 8'h30);
        cycle();
        req_valid[0] = 1'b0;
        set_port(1, 1'b1, 4'd7, 8'h20, 8'h00, 8'h31);
        set_port(2, 1'b1, 4'd8, 8'h40, 8'h00, 8'h32);
        cycle();
        check("bp_ptr", 32'(dut.r_rr_ptr), 32'd1);
        check("bp_held", 32'(dut.r_held), 32'h6);
        req_valid[1] = 1'b0;
        req_value[2*8 +: 8] = 8'h99;
        check("bp_ready2_low", 32'(req_ready[2]), 32'd0);
        cycle();
        check("bp_grant1_value", 32'(value), 32'h31);
        check("bp_ready2_grant", 32'(req_ready[2]), 32'd1);
        cycle();
        check("bp_grant2_tx", 32'(rob_transmit), 32'd1);
        check("bp_grant2_value", 32'(value), 32'h32);
        req_valid = '0;
        cycle();
        check("bp_reload_value", 32'(value), 32'h99);
        cycle();

        // Reset in the middle of operation with two parked entries.
        do_reset();
        set_port(0, 1'b1, 4'd1, 8'h00, 8'h00, 8'h61);
        set_port(1, 1'b1, 4'd2, 8'h00, 8'h00, 8'h62);
        cycle();
        req_valid = '0;
        check("mid_held_before", 32'(dut.r_held), 32'h3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_held_after", 32'(dut.r_held), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("mid_no_pulse", 32'(rob_transmit), 32'd0);
        end
        set_port(2, 1'b1, 4'd9, 8'h80, 8'h12, 8'h77);
        cycle();
        req_valid = '0;
        check("mid_e0_tx", 32'(rob_transmit), 32'd0);
        cycle();
        check("mid_e1_tx", 32'(rob_transmit), 32'd1);
        check("mid_e1_value", 32'(value), 32'h77);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 63) == 0);
            req_valid = N'($urandom);
            req_robid = (N*4)'($urandom);
            req_flags = (N*8)'($urandom);
            req_wbs   = (N*8)'($urandom);
            req_value = (N*8)'($urandom);
            cycle();
        end
        rst       = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 4; k++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
